// File: rtl/fighter_pkg.sv
// Shared types and default key maps for the per-player fighter action sequencer.
package fighter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WALK        = 3'd1,
        ST_CROUCH      = 3'd2,
        ST_ATK_START   = 3'd3,
        ST_ATK_ACTIVE  = 3'd4,
        ST_ATK_RECOVER = 3'd5,
        ST_HITSTUN     = 3'd6
    } action_state_t;

    typedef enum logic [1:0] {
        ATK_NONE  = 2'd0,
        ATK_PUNCH = 2'd1,
        ATK_KICK  = 2'd2
    } attack_type_t;

    localparam logic [7:0] P1_KEY_LEFT  = 8'h04;
    localparam logic [7:0] P1_KEY_RIGHT = 8'h07;
    localparam logic [7:0] P1_KEY_DOWN  = 8'h16;
    localparam logic [7:0] P1_KEY_UP    = 8'h1a;
    localparam logic [7:0] P1_KEY_PUNCH = 8'h09;
    localparam logic [7:0] P1_KEY_KICK  = 8'h0a;

    localparam logic [7:0] P2_KEY_LEFT  = 8'h0d;
    localparam logic [7:0] P2_KEY_RIGHT = 8'h0f;
    localparam logic [7:0] P2_KEY_DOWN  = 8'h0e;
    localparam logic [7:0] P2_KEY_UP    = 8'h0c;
    localparam logic [7:0] P2_KEY_PUNCH = 8'h33;
    localparam logic [7:0] P2_KEY_KICK  = 8'h34;

    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        return (value == 4'd15) ? 4'd15 : value + 4'd1;
    endfunction

endpackage

// File: rtl/key_match4.sv
// Reports whether a target keycode is among the four currently held keycodes.
module key_match4 (
    input  logic [7:0] keycode_0,
    input  logic [7:0] keycode_1,
    input  logic [7:0] keycode_2,
    input  logic [7:0] keycode_3,
    input  logic [7:0] target,
    output logic       match
);

    assign match = (keycode_0 == target) || (keycode_1 == target) ||
                   (keycode_2 == target) || (keycode_3 == target);

endmodule

// File: rtl/fighter_action_ctrl.sv
// Per-player action sequencer: picks walk/crouch/jump/attack from held keys,
// runs attack phases and hit-stun, and drives the position datapath terms.
module fighter_action_ctrl
    import fighter_pkg::*;
#(
    parameter logic [7:0] KEY_LEFT    = P1_KEY_LEFT,
    parameter logic [7:0] KEY_RIGHT   = P1_KEY_RIGHT,
    parameter logic [7:0] KEY_DOWN    = P1_KEY_DOWN,
    parameter logic [7:0] KEY_UP      = P1_KEY_UP,
    parameter logic [7:0] KEY_PUNCH   = P1_KEY_PUNCH,
    parameter logic [7:0] KEY_KICK    = P1_KEY_KICK,
    parameter bit         FACE_LEFT   = 1'b0,
    parameter int         WALK_SPEED  = 2,
    parameter int         P_START     = 3,
    parameter int         P_ACTIVE    = 2,
    parameter int         P_RECOVER   = 6,
    parameter int         K_START     = 5,
    parameter int         K_ACTIVE    = 3,
    parameter int         K_RECOVER   = 8,
    parameter int         STUN_FRAMES = 12,
    parameter int         KB_FRAMES   = 6,
    parameter int         KB_SPEED    = 3
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic [7:0]        keycode_0,
    input  logic [7:0]        keycode_1,
    input  logic [7:0]        keycode_2,
    input  logic [7:0]        keycode_3,
    input  logic              move_left_ok,
    input  logic              move_right_ok,
    input  logic              airborne,
    input  logic              hit_in,
    output logic signed [3:0] x_motion,
    output logic signed [3:0] knockback,
    output logic              jump_req,
    output logic              crouch,
    output logic              attack_active,
    output logic [1:0]        attack_type,
    output logic [2:0]        action_state,
    output logic [3:0]        anim_frame
);

    localparam int KI_LEFT  = 0;
    localparam int KI_RIGHT = 1;
    localparam int KI_DOWN  = 2;
    localparam int KI_UP    = 3;
    localparam int KI_PUNCH = 4;
    localparam int KI_KICK  = 5;

    localparam logic [47:0] KEY_VEC = {KEY_KICK, KEY_PUNCH, KEY_UP, KEY_DOWN, KEY_RIGHT, KEY_LEFT};

    localparam logic signed [3:0] WALK_STEP = 4'(WALK_SPEED);
    localparam logic signed [3:0] KB_STEP   = FACE_LEFT ? 4'(KB_SPEED) : -4'(KB_SPEED);
    localparam logic [4:0]        STUN_LOAD = 5'(STUN_FRAMES);
    localparam logic [4:0]        KB_FLOOR  = 5'(STUN_FRAMES - KB_FRAMES);

    logic [5:0] held;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_key
            key_match4 u_match (
                .keycode_0 (keycode_0),
                .keycode_1 (keycode_1),
                .keycode_2 (keycode_2),
                .keycode_3 (keycode_3),
                .target    (KEY_VEC[gi*8 +: 8]),
                .match     (held[gi])
            );
        end
    endgenerate

    action_state_t     state_reg, state_next;
    attack_type_t      type_reg, type_next;
    logic [4:0]        phase_reg, phase_next;
    logic [4:0]        stun_reg, stun_next;
    logic [3:0]        anim_reg, anim_next;
    logic              up_prev_reg;
    logic signed [3:0] x_motion_reg, x_motion_next;
    logic signed [3:0] knockback_reg, knockback_next;
    logic              jump_req_reg, jump_req_next;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_reg     <= ST_IDLE;
            type_reg      <= ATK_NONE;
            phase_reg     <= '0;
            stun_reg      <= '0;
            anim_reg      <= '0;
            up_prev_reg   <= 1'b0;
            x_motion_reg  <= '0;
            knockback_reg <= '0;
            jump_req_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            type_reg      <= type_next;
            phase_reg     <= phase_next;
            stun_reg      <= stun_next;
            anim_reg      <= anim_next;
            up_prev_reg   <= held[KI_UP];
            x_motion_reg  <= x_motion_next;
            knockback_reg <= knockback_next;
            jump_req_reg  <= jump_req_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        type_next      = type_reg;
        phase_next     = phase_reg;
        stun_next      = stun_reg;
        x_motion_next  = '0;
        knockback_next = '0;
        jump_req_next  = 1'b0;

        if (hit_in) begin
            state_next = ST_HITSTUN;
            stun_next  = STUN_LOAD;
            type_next  = ATK_NONE;
            phase_next = '0;
        end else begin
            case (state_reg)
                ST_ATK_START: begin
                    if (phase_reg == 5'd0) begin
                        state_next = ST_ATK_ACTIVE;
                        phase_next = (type_reg == ATK_KICK) ? 5'(K_ACTIVE - 1) : 5'(P_ACTIVE - 1);
                    end else begin
                        phase_next = phase_reg - 5'd1;
                    end
                end
                ST_ATK_ACTIVE: begin
                    if (phase_reg == 5'd0) begin
                        state_next = ST_ATK_RECOVER;
                        phase_next = (type_reg == ATK_KICK) ? 5'(K_RECOVER - 1) : 5'(P_RECOVER - 1);
                    end else begin
                        phase_next = phase_reg - 5'd1;
                    end
                end
                ST_ATK_RECOVER: begin
                    if (phase_reg == 5'd0) begin
                        state_next = ST_IDLE;
                        type_next  = ATK_NONE;
                    end else begin
                        phase_next = phase_reg - 5'd1;
                    end
                end
                ST_HITSTUN: begin
                    // Leave on the frame the counter would hit zero, so the stun lasts STUN_FRAMES frames.
                    if (stun_reg <= 5'd1) begin
                        state_next = ST_IDLE;
                        stun_next  = '0;
                    end else begin
                        stun_next = stun_reg - 5'd1;
                    end
                end
                default: begin
                    if (!airborne && held[KI_PUNCH]) begin
                        state_next = ST_ATK_START;
                        type_next  = ATK_PUNCH;
                        phase_next = 5'(P_START - 1);
                    end else if (!airborne && held[KI_KICK]) begin
                        state_next = ST_ATK_START;
                        type_next  = ATK_KICK;
                        phase_next = 5'(K_START - 1);
                    end else begin
                        jump_req_next = held[KI_UP] && !up_prev_reg && !airborne;
                        if (held[KI_DOWN]) begin
                            state_next = ST_CROUCH;
                        end else if (held[KI_LEFT] && !held[KI_RIGHT]) begin
                            state_next    = ST_WALK;
                            x_motion_next = move_left_ok ? -WALK_STEP : 4'sd0;
                        end else if (held[KI_RIGHT] && !held[KI_LEFT]) begin
                            state_next    = ST_WALK;
                            x_motion_next = move_right_ok ? WALK_STEP : 4'sd0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
            endcase
        end

        if (state_next == ST_HITSTUN && stun_next > KB_FLOOR) begin
            knockback_next = KB_STEP;
        end

        anim_next = (state_next != state_reg) ? 4'd0 : sat_inc4(anim_reg);
    end

    assign x_motion      = x_motion_reg;
    assign knockback     = knockback_reg;
    assign jump_req      = jump_req_reg;
    assign crouch        = (state_reg == ST_CROUCH);
    assign attack_active = (state_reg == ST_ATK_ACTIVE);
    assign attack_type   = (state_reg == ST_ATK_START || state_reg == ST_ATK_ACTIVE ||
                            state_reg == ST_ATK_RECOVER) ? type_reg : ATK_NONE;
    assign action_state  = state_reg;
    assign anim_frame    = anim_reg;

endmodule

// File: tb/tb_fighter_action_ctrl.sv
// Directed bench for fighter_action_ctrl: a P1 instance and a P2 (face-left) instance on shared keys.
module tb_fighter_action_ctrl;
    import fighter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] k0, k1, k2, k3;
    logic left_ok, right_ok, airborne, hit1, hit2;

    logic signed [3:0] x1, kb1, x2, kb2;
    logic jump1, crouch1, act1, jump2, crouch2, act2;
    logic [1:0] type1, type2;
    logic [2:0] st1, st2;
    logic [3:0] anim1, anim2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fighter_action_ctrl u_p1 (
        .frame_clk(clk), .Reset(rst),
        .keycode_0(k0), .keycode_1(k1), .keycode_2(k2), .keycode_3(k3),
        .move_left_ok(left_ok), .move_right_ok(right_ok), .airborne(airborne), .hit_in(hit1),
        .x_motion(x1), .knockback(kb1), .jump_req(jump1), .crouch(crouch1),
        .attack_active(act1), .attack_type(type1), .action_state(st1), .anim_frame(anim1)
    );

    fighter_action_ctrl #(
        .KEY_LEFT(P2_KEY_LEFT), .KEY_RIGHT(P2_KEY_RIGHT), .KEY_DOWN(P2_KEY_DOWN),
        .KEY_UP(P2_KEY_UP), .KEY_PUNCH(P2_KEY_PUNCH), .KEY_KICK(P2_KEY_KICK),
        .FACE_LEFT(1'b1)
    ) u_p2 (
        .frame_clk(clk), .Reset(rst),
        .keycode_0(k0), .keycode_1(k1), .keycode_2(k2), .keycode_3(k3),
        .move_left_ok(left_ok), .move_right_ok(right_ok), .airborne(airborne), .hit_in(hit2),
        .x_motion(x2), .knockback(kb2), .jump_req(jump2), .crouch(crouch2),
        .attack_active(act2), .attack_type(type2), .action_state(st2), .anim_frame(anim2)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; k0 = 8'h00; k1 = 8'h00; k2 = 8'h00; k3 = 8'h00;
        left_ok = 1'b0; right_ok = 1'b0; airborne = 1'b0; hit1 = 1'b0; hit2 = 1'b0;
        step();
        rst = 1'b0;

        // 1: reset in the middle of a kick's active phase
        k0 = P1_KEY_KICK;
        step();
        k0 = 8'h00;
        for (int i = 0; i < 5; i++) step();
        check("kick_active_state", st1, 4);
        check("kick_active_flag", act1, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_state", st1, 0);
        check("rst_x", x1, 0);
        check("rst_kb", kb1, 0);
        check("rst_jump", jump1, 0);
        check("rst_crouch", crouch1, 0);
        check("rst_active", act1, 0);
        check("rst_type", type1, 0);
        check("rst_anim", anim1, 0);
        check("rst_p2_bits", {x2, kb2, jump2, crouch2, act2, type2, st2, anim2}, 0);

        // 2: single-frame punch press
        k0 = P1_KEY_PUNCH;
        for (int f = 1; f <= 12; f++) begin
            step();
            if (f == 1) begin
                k0 = 8'h00;
                check("punch_start_state", st1, 3);
            end
            check($sformatf("punch_active_f%0d", f), act1, (f == 4 || f == 5) ? 1 : 0);
            check($sformatf("punch_type_f%0d", f), type1, (f <= 11) ? 1 : 0);
        end
        check("punch_end_idle", st1, 0);

        // 3: walking and blocked steps
        k0 = P1_KEY_RIGHT; right_ok = 1'b1;
        step();
        check("walk_r_state", st1, 1);
        check("walk_r_x", x1, 2);
        check("walk_r_anim0", anim1, 0);
        step();
        check("walk_r_x2", x1, 2);
        check("walk_r_anim1", anim1, 1);
        right_ok = 1'b0;
        step();
        check("walk_r_blocked_x", x1, 0);
        check("walk_r_blocked_state", st1, 1);
        k0 = P1_KEY_LEFT; left_ok = 1'b1;
        step();
        check("walk_l_x", x1, -2);
        k1 = P1_KEY_RIGHT;
        step();
        check("both_dirs_state", st1, 0);
        check("both_dirs_x", x1, 0);
        k0 = P1_KEY_DOWN; k1 = 8'h00;
        step();
        check("crouch_state", st1, 2);
        check("crouch_flag", crouch1, 1);
        check("crouch_x", x1, 0);
        k0 = 8'h00; left_ok = 1'b0;
        step();
        check("release_idle", st1, 0);

        // 4: P2 hit during kick startup, knockback toward +X
        k0 = P2_KEY_KICK;
        step();
        check("p2_kick_start", st2, 3);
        check("p2_kick_type", type2, 2);
        k0 = 8'h00;
        step();
        hit2 = 1'b1;
        for (int j = 1; j <= 13; j++) begin
            step();
            hit2 = 1'b0;
            check($sformatf("p2_stun_state_j%0d", j), st2, (j <= 12) ? 6 : 0);
            check($sformatf("p2_kb_j%0d", j), kb2, (j <= 6) ? 3 : 0);
            check($sformatf("p2_active_j%0d", j), act2, 0);
        end
        check("p2_stun_type_cleared", type2, 0);

        // P1 hit, then re-hit during stun restarts counter and knockback (toward -X)
        hit1 = 1'b1;
        step();
        hit1 = 1'b0;
        check("p1_hit_state", st1, 6);
        check("p1_hit_kb", kb1, -3);
        step();
        step();
        hit1 = 1'b1;
        for (int j = 1; j <= 13; j++) begin
            step();
            hit1 = 1'b0;
            check($sformatf("p1_rehit_state_j%0d", j), st1, (j <= 12) ? 6 : 0);
            check($sformatf("p1_rehit_kb_j%0d", j), kb1, (j <= 6) ? -3 : 0);
        end

        // 5: jump request is edge-triggered on the up key
        k0 = P1_KEY_UP;
        for (int f = 1; f <= 10; f++) begin
            step();
            check($sformatf("jump_hold_f%0d", f), jump1, (f == 1) ? 1 : 0);
        end
        check("jump_hold_state", st1, 0);
        k0 = 8'h00;
        step();
        check("jump_release", jump1, 0);
        k0 = P1_KEY_UP;
        step();
        check("jump_repress", jump1, 1);
        step();
        check("jump_repress_hold", jump1, 0);
        k0 = 8'h00;
        step();
        airborne = 1'b1; k0 = P1_KEY_UP;
        step();
        check("jump_airborne", jump1, 0);
        k0 = 8'h00;

        // 6: punch+kick while airborne is ignored; on ground punch wins
        k0 = P1_KEY_PUNCH; k1 = P1_KEY_KICK;
        step();
        check("air_attack_state", st1, 0);
        check("air_attack_type", type1, 0);
        airborne = 1'b0;
        step();
        k0 = 8'h00; k1 = 8'h00;
        check("ground_attack_state", st1, 3);
        check("ground_attack_type", type1, 1);
        for (int f = 2; f <= 12; f++) begin
            step();
            check($sformatf("pk_active_f%0d", f), act1, (f == 4 || f == 5) ? 1 : 0);
            check($sformatf("pk_type_f%0d", f), type1, (f <= 11) ? 1 : 0);
        end
        check("pk_end_idle", st1, 0);
        check("pk_end_anim", anim1, 0);

        // anim_frame saturates at 15 while parked in IDLE
        for (int f = 0; f < 20; f++) step();
        check("anim_saturate", anim1, 15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
